riscv_multicycle_ctrl: RTL

//  Multicycle main controller for the RISC-V core; replaces the single-cycle Controller+ALUController pair.

---
 rtl/riscv_multicycle_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multicycle RISC-V main controller sequencing a shared datapath over one
// variable-latency memory port, with memory timeout, illegal-opcode fault and retired-instruction count.
module riscv_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RET_CNT_W    = 32,
  parameter bit EN_BRANCH    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_cc,
  output logic                 fault,
  output logic [RET_CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, FAULT
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [3:0] CC_AND = 4'b0000, CC_OR = 4'b0001, CC_ADD = 4'b0010, CC_SUB = 4'b0110;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [RET_CNT_W-1:0] ret_q, ret_d;
  logic legal, is_mem, timeout, retire;
  logic [3:0] dec_cc;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:         legal = (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                            ((funct3 == 3'b111 || funct3 == 3'b110) && funct7 == 7'b0000000);
      OP_I:         legal = funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110;
      OP_LD, OP_ST: legal = 1'b1;
      OP_BR:        legal = EN_BRANCH && funct3 == 3'b000;
      default:      legal = 1'b0;
    endcase
  end
  assign dec_cc = funct3 == 3'b111 ? CC_AND : funct3 == 3'b110 ? CC_OR :
                  (opcode == OP_R && funct7[5]) ? CC_SUB : CC_ADD;
  assign is_mem  = state_q inside {FETCH, MEM_RD, MEM_WR};
  assign timeout = is_mem && !mem_ready && cnt_q == 8'(MEM_WAIT_MAX);
  assign retire  = state_q inside {WB_ALU, WB_MEM, BRANCH} || (state_q == MEM_WR && mem_ready);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:          state_d = mem_ready ? DECODE : FETCH;
      DECODE:         state_d = !legal ? FAULT : opcode == OP_R ? EXEC_R : opcode == OP_I ? EXEC_I :
                                opcode == OP_BR ? BRANCH : MEM_ADDR;
      EXEC_R, EXEC_I: state_d = WB_ALU;
      WB_ALU, WB_MEM: state_d = FETCH;
      BRANCH:         state_d = FETCH;
      MEM_ADDR:       state_d = opcode == OP_LD ? MEM_RD : MEM_WR;
      MEM_RD:         state_d = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:         state_d = mem_ready ? FETCH : MEM_WR;
      default:        state_d = FAULT;
    endcase
    if (timeout) state_d = FAULT;
  end
  // Any state change clears the wait count, so each new access starts from zero.
  assign cnt_d = state_d != state_q ? 8'd0 : (is_mem && !mem_ready) ? cnt_q + 8'd1 : cnt_q;
  assign ret_d = retire ? ret_q + RET_CNT_W'(1) : ret_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end
  // Controls are gated by reset so nothing is enabled while reset is held low.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_cc     = 4'd0;
    fault      = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH:    begin mem_read = 1'b1; alu_src_b = 2'd1; alu_cc = CC_ADD;
                        ir_write = mem_ready; pc_write = mem_ready; end
        DECODE:   begin alu_src_b = 2'd2; alu_cc = CC_ADD; end
        EXEC_R:   begin alu_src_a = 1'b1; alu_cc = dec_cc; end
        EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_cc = dec_cc; end
        WB_ALU:   reg_write = 1'b1;
        MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_cc = CC_ADD; end
        MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
        WB_MEM:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; end
        BRANCH:   begin alu_src_a = 1'b1; alu_cc = CC_SUB; pc_write = zero; pc_src = 1'b1; end
        default:  fault = 1'b1;
      endcase
    end
  end
  assign retired = ret_q;
endmodule
